led_pattern_driver: RTL and testbench



---
 rtl/led_pattern_driver.sv | 120 ++++++++++++
 tb/tb_led_pattern_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_driver.sv
// LED pin driver fed by the green-LED PIO: global PWM brightness plus
// static / blink / chase / off display modes, timed from a clock prescaler.
module led_pattern_driver #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 50000,
   parameter int HALF_W   = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  pattern_in,
   input  logic [1:0]        mode,
   input  logic [7:0]        duty,
   input  logic [HALF_W-1:0] blink_half,
   output logic [WIDTH-1:0]  led_out,
   output logic              tick_out
);

   localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_BLINK  = 2'd1;
   localparam logic [1:0] MODE_CHASE  = 2'd2;

   logic [WIDTH-1:0]  pattern_q;
   logic [1:0]        mode_q;
   logic [7:0]        duty_q;
   logic [HALF_W-1:0] half_q;

   logic [PRE_W-1:0]  pre_cnt;
   logic [7:0]        pwm_cnt;
   logic [HALF_W-1:0] step_cnt;
   logic              blink_phase;
   logic [WIDTH-1:0]  chase_mask;

   logic [HALF_W-1:0] eff_half;
   logic              step_last;
   logic              pwm_on;
   logic              mode_change;
   logic [WIDTH-1:0]  gate_next;
   logic [WIDTH-1:0]  led_next;

   assign eff_half    = (half_q == '0) ? HALF_W'(1) : half_q;
   // >= so that shrinking blink_half mid-count ends the current step promptly
   assign step_last   = (step_cnt >= (eff_half - HALF_W'(1)));
   assign pwm_on      = (duty_q == 8'hFF) | (pwm_cnt < duty_q);
   assign mode_change = (mode != mode_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= '0;
         mode_q    <= '0;
         duty_q    <= '0;
         half_q    <= '0;
      end else begin
         pattern_q <= pattern_in;
         mode_q    <= mode;
         duty_q    <= duty;
         half_q    <= blink_half;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt  <= '0;
         tick_out <= 1'b0;
         pwm_cnt  <= '0;
      end else begin
         pre_cnt  <= (pre_cnt == PRE_W'(PRESCALE - 1)) ? '0 : pre_cnt + PRE_W'(1);
         tick_out <= (pre_cnt == PRE_W'(PRESCALE - 1));
         pwm_cnt  <= pwm_cnt + 8'd1;
      end
   end

   // Shared step timer for blink and chase; a mode change takes priority over a tick
   always_ff @(posedge clk) begin
      if (reset) begin
         step_cnt    <= '0;
         blink_phase <= 1'b1;
         chase_mask  <= WIDTH'(1);
      end else if (mode_change) begin
         step_cnt    <= '0;
         blink_phase <= 1'b1;
         chase_mask  <= WIDTH'(1);
      end else if (tick_out) begin
         if (step_last) begin
            step_cnt    <= '0;
            blink_phase <= ~blink_phase;
            chase_mask  <= {chase_mask[WIDTH-2:0], chase_mask[WIDTH-1]};
         end else begin
            step_cnt <= step_cnt + HALF_W'(1);
         end
      end
   end

   always_comb begin
      gate_next = '0;
      case (mode_q)
         MODE_STATIC: gate_next = {WIDTH{pwm_on}};
         MODE_BLINK:  gate_next = {WIDTH{blink_phase & pwm_on}};
         MODE_CHASE:  gate_next = chase_mask & {WIDTH{pwm_on}};
         default:     gate_next = '0;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_led
         assign led_next[gi] = pattern_q[gi] & gate_next[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         led_out <= '0;
      end else begin
         led_out <= led_next;
      end
   end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: directed stimulus pushes per-cycle expected
// led_out values; a negedge monitor pops and compares them.
module tb_led_pattern_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pattern_in;
   logic [1:0] mode;
   logic [7:0] duty;
   logic [9:0] blink_half;
   logic [7:0] led_out;
   logic       tick_out;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [7:0] exp;
      string      name;
   } sb_t;
   sb_t sb[$];

   led_pattern_driver #(.WIDTH(8), .PRESCALE(4), .HALF_W(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .pattern_in (pattern_in),
      .mode       (mode),
      .duty       (duty),
      .blink_half (blink_half),
      .led_out    (led_out),
      .tick_out   (tick_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic expect_range(input string name, input int c0, input int c1, input logic [7:0] v);
      for (int c = c0; c <= c1; c++) begin
         sb_t e;
         e.cyc  = c;
         e.exp  = v;
         e.name = name;
         sb.push_back(e);
      end
   endtask

   // Monitor: compare led_out whenever an expectation for this cycle is queued
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                  sb[0].name, sb[0].cyc, cyc);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         sb_t e;
         e = sb.pop_front();
         check(e.name, {24'd0, led_out}, {24'd0, e.exp});
      end
   end

   task automatic goto_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left pending", sb.size());
         sb.delete();
      end
   endtask

   task automatic wait_tick(output int t);
      for (int i = 0; i < 16 && tick_out !== 1'b1; i++) @(negedge clk);
      check("tick_align", {31'd0, tick_out}, 32'd1);
      t = cyc;
   endtask

   initial begin
      int t, n, c0, c2, c5, c7, cother, first_tick, ticks, bad_ticks;

      reset      = 1'b1;
      pattern_in = 8'hFF;
      mode       = 2'd0;
      duty       = 8'd255;
      blink_half = 10'd3;

      // Reset held for edges 1..3, released before edge 4
      expect_range("reset_hold", 1, 3, 8'h00);
      goto_cyc(2);
      check("reset_tick", {31'd0, tick_out}, 32'd0);
      goto_cyc(3);
      reset = 1'b0;
      expect_range("reset_exit_lat", 4, 4, 8'h00);
      expect_range("reset_exit_on", 5, 8, 8'hFF);

      // Prescaler: first tick after edge 7, then every 4 cycles
      goto_cyc(5);
      first_tick = -1;
      ticks = 0;
      bad_ticks = 0;
      for (int i = 0; i < 40; i++) begin
         if (tick_out === 1'b1) begin
            if (first_tick < 0) first_tick = cyc;
            ticks++;
            if ((cyc % 4) != 3) bad_ticks++;
         end
         @(negedge clk);
      end
      check("tick_first", first_tick, 7);
      check("tick_count", ticks, 10);
      check("tick_spacing", bad_ticks, 0);
      drain();

      // Reset mid-run
      n = cyc;
      reset = 1'b1;
      expect_range("midreset", n + 1, n + 2, 8'h00);
      expect_range("midreset_exit", n + 3, n + 5, 8'hFF);
      goto_cyc(n + 1);
      reset = 1'b0;
      drain();

      // PWM duty 64 on pattern A5
      n = cyc;
      pattern_in = 8'hA5;
      duty = 8'd64;
      goto_cyc(n + 2);
      c0 = 0; c2 = 0; c5 = 0; c7 = 0; cother = 0;
      for (int i = 0; i < 256; i++) begin
         if (led_out[0]) c0++;
         if (led_out[2]) c2++;
         if (led_out[5]) c5++;
         if (led_out[7]) c7++;
         if ((led_out & 8'h5A) != 8'h00) cother++;
         @(negedge clk);
      end
      check("pwm64_bit0", c0, 64);
      check("pwm64_bit2", c2, 64);
      check("pwm64_bit5", c5, 64);
      check("pwm64_bit7", c7, 64);
      check("pwm64_others", cother, 0);

      n = cyc;
      duty = 8'd0;
      expect_range("pwm_duty0", n + 2, n + 9, 8'h00);
      drain();
      n = cyc;
      duty = 8'd255;
      expect_range("pwm_duty255", n + 2, n + 9, 8'hA5);
      drain();

      // Blink: 12 cycles on, 12 off
      wait_tick(t);
      mode = 2'd1;
      pattern_in = 8'h3C;
      expect_range("blink_on1", t + 2, t + 13, 8'h3C);
      expect_range("blink_off", t + 14, t + 25, 8'h00);
      expect_range("blink_on2", t + 26, t + 37, 8'h3C);
      drain();

      // Chase with blink_half=1
      wait_tick(t);
      mode = 2'd2;
      pattern_in = 8'hFF;
      blink_half = 10'd1;
      for (int k = 0; k < 8; k++)
         expect_range("chase_h1", t + 2 + 4 * k, t + 5 + 4 * k, 8'h01 << k);
      expect_range("chase_h1_wrap", t + 34, t + 37, 8'h01);
      drain();

      // Chase with blink_half=0, interrupted at mask 10 by a blink detour
      n = cyc;
      mode = 2'd0;
      goto_cyc(n + 2);
      wait_tick(t);
      mode = 2'd2;
      blink_half = 10'd0;
      for (int k = 0; k < 4; k++)
         expect_range("chase_h0", t + 2 + 4 * k, t + 5 + 4 * k, 8'h01 << k);
      expect_range("chase_h0_m10", t + 18, t + 20, 8'h10);
      expect_range("chase_detour", t + 21, t + 21, 8'hFF);
      expect_range("chase_restart", t + 22, t + 25, 8'h01);
      expect_range("chase_restart_step", t + 26, t + 29, 8'h02);
      goto_cyc(t + 19);
      mode = 2'd1;
      goto_cyc(t + 20);
      mode = 2'd2;
      drain();

      // Blink restart from the off phase via 1->0->1
      wait_tick(t);
      mode = 2'd1;
      pattern_in = 8'h3C;
      blink_half = 10'd3;
      expect_range("blinkrs_on", t + 2, t + 13, 8'h3C);
      expect_range("blinkrs_off", t + 14, t + 17, 8'h00);
      expect_range("blinkrs_restart", t + 18, t + 29, 8'h3C);
      expect_range("blinkrs_off2", t + 30, t + 33, 8'h00);
      goto_cyc(t + 16);
      mode = 2'd0;
      goto_cyc(t + 17);
      mode = 2'd1;
      drain();

      // Off mode, then back to static
      n = cyc;
      mode = 2'd3;
      pattern_in = 8'hA5;
      duty = 8'd128;
      expect_range("off", n + 2, n + 7, 8'h00);
      expect_range("off_exit", n + 8, n + 11, 8'hA5);
      goto_cyc(n + 6);
      mode = 2'd0;
      duty = 8'd255;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
